// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. One operand bit pair is consumed per clock,
// LSB first, through a full adder built from two half_adder cells and an OR
// gate. A carry flip-flop closes the loop around the full adder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   start      request a new addition (accepted in IDLE or DONE)
//   a, b       WIDTH-bit operands, captured only on an accepted start
//   busy       high while the addition is running
//   done       one-cycle pulse; sum/carry_out are updated in this cycle
//   sum        (a+b) mod 2^WIDTH, held until the next done
//   carry_out  bit WIDTH of a+b, held with sum
//
// Also contains the half_adder cell used to build the full adder.
// -----------------------------------------------------------------------------

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;

  logic             ha1_sum;
  logic             ha1_carry;
  logic             ha2_sum;
  logic             ha2_carry;
  logic             c_next;

  // Full adder: HA1 adds the operand bits, HA2 folds in the running carry.
  half_adder ha1 (
    .a     (sa[0]),
    .b     (sb[0]),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  half_adder ha2 (
    .a     (ha1_sum),
    .b     (c),
    .sum   (ha2_sum),
    .carry (ha2_carry)
  );

  assign c_next   = ha1_carry | ha2_carry;
  assign last_bit = (cnt == LAST_CNT);

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at acc[0].
  // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = ha2_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result registers are written only on the final RUN edge so the outputs
  // never expose a partially accumulated sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      c   <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= acc_next;
      c   <= c_next;
      cnt <= cnt + ONE_CNT;
      if (last_bit) begin
        sum       <= acc_next;
        carry_out <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed self-checking bench for serial_adder. Three instances (WIDTH=8,
// 1 and 16) share clock and reset; a selector routes the common stimulus
// buses to one instance at a time and muxes its outputs back.
// -----------------------------------------------------------------------------

module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        startReq;
  logic [31:0] aBus;
  logic [31:0] bBus;
  int          sel;

  int compareCount;
  int mismatchCount;

  logic        start8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        carry8;

  logic        start1;
  logic        busy1;
  logic        done1;
  logic [0:0]  sum1;
  logic        carry1;

  logic        start16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        carry16;

  logic [31:0] obsSum;
  logic        obsCarry;
  logic        obsBusy;
  logic        obsDone;

  assign start8  = startReq && (sel == 8);
  assign start1  = startReq && (sel == 1);
  assign start16 = startReq && (sel == 16);

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .a         (aBus[7:0]),
    .b         (bBus[7:0]),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .carry_out (carry8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .a         (aBus[0:0]),
    .b         (bBus[0:0]),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (carry1)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .a         (aBus[15:0]),
    .b         (bBus[15:0]),
    .busy      (busy16),
    .done      (done16),
    .sum       (sum16),
    .carry_out (carry16)
  );

  always_comb begin
    obsSum   = '0;
    obsCarry = 1'b0;
    obsBusy  = 1'b0;
    obsDone  = 1'b0;
    case (sel)
      1: begin
        obsSum   = {31'b0, sum1};
        obsCarry = carry1;
        obsBusy  = busy1;
        obsDone  = done1;
      end
      16: begin
        obsSum   = {16'b0, sum16};
        obsCarry = carry16;
        obsBusy  = busy16;
        obsDone  = done16;
      end
      default: begin
        obsSum   = {24'b0, sum8};
        obsCarry = carry8;
        obsBusy  = busy8;
        obsDone  = done8;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete addition on the selected instance: start pulse, bounded wait
  // for done, then latency, busy length, result and done-deassert checks.
  task automatic applyStimulus(input int w, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] expSum,
                               input logic expCarry);
    int   edges;
    int   busyCycles;
    logic overlap;
    sel      = w;
    aBus     = av;
    bBus     = bv;
    startReq = 1'b1;
    @(posedge clk);
    #1;
    startReq   = 1'b0;
    edges      = 1;
    busyCycles = obsBusy ? 1 : 0;
    overlap    = obsBusy && obsDone;
    while (!obsDone && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (obsBusy) busyCycles++;
      if (obsBusy && obsDone) overlap = 1'b1;
    end
    checkOutput($sformatf("w%0d latency", w), edges, w + 1);
    checkOutput($sformatf("w%0d busy cycles", w), busyCycles, w);
    checkOutput($sformatf("w%0d busy&done", w), {31'b0, overlap}, 32'd0);
    checkOutput($sformatf("w%0d sum %0h+%0h", w, av, bv), obsSum, expSum);
    checkOutput($sformatf("w%0d carry %0h+%0h", w, av, bv), {31'b0, obsCarry},
                {31'b0, expCarry});
    @(posedge clk);
    #1;
    checkOutput($sformatf("w%0d done drop", w), {31'b0, obsDone}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vec8[4];
  vec_t vec1[4];
  vec_t vec16[3];

  initial begin
    int          doneCount;
    int          doneEdge;
    logic [31:0] doneSum;
    logic        doneCarry;
    logic        stable;
    logic        sawDone;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] full;

    compareCount  = 0;
    mismatchCount = 0;
    sel      = 8;
    startReq = 1'b0;
    aBus     = '0;
    bBus     = '0;
    rst_n    = 1'b0;

    vec8[0] = '{32'h00, 32'h00, 32'h00, 1'b0};
    vec8[1] = '{32'hFF, 32'h01, 32'h00, 1'b1};
    vec8[2] = '{32'hA5, 32'h5A, 32'hFF, 1'b0};
    vec8[3] = '{32'hFF, 32'hFF, 32'hFE, 1'b1};

    vec1[0] = '{32'h0, 32'h0, 32'h0, 1'b0};
    vec1[1] = '{32'h1, 32'h0, 32'h1, 1'b0};
    vec1[2] = '{32'h0, 32'h1, 32'h1, 1'b0};
    vec1[3] = '{32'h1, 32'h1, 32'h0, 1'b1};

    vec16[0] = '{32'hFFFF, 32'h0001, 32'h0000, 1'b1};
    vec16[1] = '{32'h1234, 32'h4321, 32'h5555, 1'b0};
    vec16[2] = '{32'h8000, 32'h8000, 32'h0000, 1'b1};

    #3;
    checkOutput("reset busy", {31'b0, busy8}, 32'd0);
    checkOutput("reset done", {31'b0, done8}, 32'd0);
    checkOutput("reset sum", {24'b0, sum8}, 32'd0);
    checkOutput("reset carry", {31'b0, carry8}, 32'd0);
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed WIDTH=8 vectors");
    foreach (vec8[i]) applyStimulus(8, vec8[i].av, vec8[i].bv, vec8[i].s, vec8[i].c);

    $display("[TB] start during RUN must be ignored");
    sel      = 8;
    aBus     = 32'h0F;
    bBus     = 32'h01;
    startReq = 1'b1;
    @(posedge clk);
    #1;
    startReq  = 1'b0;
    doneCount = 0;
    doneEdge  = -1;
    doneSum   = '0;
    doneCarry = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (obsDone) begin
        doneCount++;
        doneEdge  = e;
        doneSum   = obsSum;
        doneCarry = obsCarry;
      end
      if (e == 3) begin
        aBus     = 32'hF0;
        startReq = 1'b1;
      end
      if (e == 4) startReq = 1'b0;
    end
    checkOutput("restart done count", doneCount, 1);
    checkOutput("restart done edge", doneEdge, 8);
    checkOutput("restart sum", doneSum, 32'h10);
    checkOutput("restart carry", {31'b0, doneCarry}, 32'd0);

    $display("[TB] start held high, back-to-back");
    aBus      = 32'h10;
    bBus      = 32'h20;
    startReq  = 1'b1;
    doneCount = 0;
    stable    = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (obsDone) doneCount++;
      if (e == 0) begin
        aBus = 32'h80;
        bBus = 32'h80;
      end
      if (e == 8) begin
        checkOutput("b2b first done", {31'b0, obsDone}, 32'd1);
        checkOutput("b2b first sum", obsSum, 32'h30);
        checkOutput("b2b first carry", {31'b0, obsCarry}, 32'd0);
      end
      if (e > 8 && e < 17 && obsSum != 32'h30) stable = 1'b0;
      if (e == 17) begin
        checkOutput("b2b second done", {31'b0, obsDone}, 32'd1);
        checkOutput("b2b second sum", obsSum, 32'h00);
        checkOutput("b2b second carry", {31'b0, obsCarry}, 32'd1);
      end
    end
    startReq = 1'b0;
    checkOutput("b2b done count", doneCount, 2);
    checkOutput("b2b sum stable", {31'b0, stable}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b idle busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("b2b idle done", {31'b0, obsDone}, 32'd0);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(8, 32'h10, 32'h20, 32'h30, 1'b0);
    aBus     = 32'h12;
    bBus     = 32'h34;
    startReq = 1'b1;
    @(posedge clk);
    #1;
    startReq = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort sum", obsSum, 32'h0);
    checkOutput("abort carry", {31'b0, obsCarry}, 32'd0);
    checkOutput("abort busy", {31'b0, obsBusy}, 32'd0);
    sawDone = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (obsDone) sawDone = 1'b1;
    end
    #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (obsDone) sawDone = 1'b1;
    end
    checkOutput("abort no done", {31'b0, sawDone}, 32'd0);
    applyStimulus(8, 32'h12, 32'h34, 32'h46, 1'b0);

    $display("[TB] WIDTH=1 and WIDTH=16 vectors");
    foreach (vec1[i]) applyStimulus(1, vec1[i].av, vec1[i].bv, vec1[i].s, vec1[i].c);
    foreach (vec16[i]) applyStimulus(16, vec16[i].av, vec16[i].bv, vec16[i].s, vec16[i].c);

    $display("[TB] short random sweep");
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom_range(0, 255);
      rb   = $urandom_range(0, 255);
      full = {1'b0, ra} + {1'b0, rb};
      applyStimulus(8, ra, rb, full[31:0] & 32'hFF, full[8]);
    end
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom_range(0, 65535);
      rb   = $urandom_range(0, 65535);
      full = {1'b0, ra} + {1'b0, rb};
      applyStimulus(16, ra, rb, full[31:0] & 32'hFFFF, full[16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
